// File: rtl/mm_matvec_stream.sv
// Streaming NxN signed matrix-by-vector multiplier: operands are loaded over a
// valid/ready stream, multiplied on one pipelined MAC, and results streamed out.
module mm_matvec_stream #(
  parameter int N            = 3,
  parameter int NBITS        = 16,
  parameter int RESULT_WIDTH = 32,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [NBITS-1:0]        in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [RESULT_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           out_ovf,
  output logic                           busy,
  output logic                           err
);

  localparam int ACC_W = 2*NBITS + $clog2(N);
  localparam int PW    = 2*NBITS;
  localparam int NOPS  = N*N + N;
  localparam int JW    = $clog2(NOPS);
  localparam int IW    = $clog2(N);
  localparam int WW    = ((ACC_W > RESULT_WIDTH) ? ACC_W : RESULT_WIDTH) + 1;

  localparam logic [JW-1:0] LAST_BEAT = JW'(NOPS - 1);
  localparam logic [JW-1:0] B_BASE    = JW'(N*N);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  // Range limits of the result word, held one bit wider than either operand.
  localparam logic signed [WW-1:0] RMAX = {{(WW-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] RMIN = ~RMAX;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  function automatic logic ovf_chk(input logic signed [ACC_W-1:0] v);
    logic signed [WW-1:0] ve;
    ve = WW'(v);
    return (ve > RMAX) || (ve < RMIN);
  endfunction

  function automatic logic signed [RESULT_WIDTH-1:0] conv(input logic signed [ACC_W-1:0] v);
    logic signed [WW-1:0] ve;
    ve = WW'(v);
    if (SATURATE && (ve > RMAX)) return RMAX[RESULT_WIDTH-1:0];
    if (SATURATE && (ve < RMIN)) return RMIN[RESULT_WIDTH-1:0];
    return ve[RESULT_WIDTH-1:0];
  endfunction

  state_t                          state;
  logic [JW-1:0]                   lcnt;
  logic                            iss;
  logic [JW-1:0]                   mac_j;
  logic [IW-1:0]                   mac_r, mac_c;
  logic [IW-1:0]                   oidx, onxt;
  logic                            vld_p1, last_p1, fin_p2;

  logic signed [NBITS-1:0]         ops [NOPS];
  logic signed [PW-1:0]            prod_p1;
  logic [IW-1:0]                   i_p1, k_p1;
  logic signed [ACC_W-1:0]         acc_p2, acc_base, acc_sum;
  logic signed [RESULT_WIDTH-1:0]  res [N];
  logic                            res_ovf [N];

  assign onxt     = oidx + 1'b1;
  assign acc_base = (k_p1 == '0) ? ACC_W'(0) : acc_p2;
  assign acc_sum  = acc_base + ACC_W'(prod_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      lcnt      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      iss       <= 1'b0;
      mac_j     <= '0;
      mac_r     <= '0;
      mac_c     <= '0;
      oidx      <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      fin_p2    <= 1'b0;
    end else begin
      vld_p1  <= iss;
      last_p1 <= iss && (mac_r == IDX_LAST) && (mac_c == IDX_LAST);
      fin_p2  <= vld_p1 && last_p1;
      if (iss) begin
        mac_j <= mac_j + 1'b1;
        if (mac_c == IDX_LAST) begin
          mac_c <= '0;
          mac_r <= mac_r + 1'b1;
          if (mac_r == IDX_LAST) iss <= 1'b0;
        end else begin
          mac_c <= mac_c + 1'b1;
        end
      end
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            if (in_last != (lcnt == LAST_BEAT)) err <= 1'b1;
            if (lcnt == LAST_BEAT) begin
              lcnt     <= '0;
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              iss      <= 1'b1;
              mac_j    <= '0;
              mac_r    <= '0;
              mac_c    <= '0;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (fin_p2) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_data  <= res[0];
            out_ovf   <= res_ovf[0];
            out_last  <= 1'b0;
            oidx      <= '0;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (oidx == IDX_LAST) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              oidx     <= onxt;
              out_data <= res[onxt];
              out_ovf  <= res_ovf[onxt];
              out_last <= (onxt == IDX_LAST);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) ops[lcnt] <= in_data;
    // Stage 1: product of A[i][k] and B[k]
    if (iss) begin
      prod_p1 <= PW'(ops[mac_j]) * PW'(ops[B_BASE + JW'(mac_c)]);
      i_p1    <= mac_r;
      k_p1    <= mac_c;
    end
    // Stage 2: accumulate; row sum converted and stored on the last column
    if (vld_p1) begin
      acc_p2 <= acc_sum;
      if (k_p1 == IDX_LAST) begin
        res[i_p1]     <= conv(acc_sum);
        res_ovf[i_p1] <= ovf_chk(acc_sum);
      end
    end
  end

endmodule

// File: tb/tb_mm_matvec_stream.sv
// Scoreboard bench for mm_matvec_stream: saturating and wrapping N=3 instances
// share one input stream; an N=4 / 8-bit instance has its own stream.
module tb_mm_matvec_stream;

  typedef struct {
    longint d;
    bit     o;
    bit     l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in3_valid = 1'b0, in3_last = 1'b0, out_ready = 1'b1;
  logic signed [15:0] in3_data = '0;
  logic               in3_ready, o3_valid, o3_last, o3_ovf, busy3, err3;
  logic signed [31:0] o3_data;
  logic               in3w_ready, o3w_valid, o3w_last, o3w_ovf, busy3w, err3w;
  logic signed [31:0] o3w_data;

  logic               in4_valid = 1'b0, in4_last = 1'b0;
  logic signed [7:0]  in4_data = '0;
  logic               in4_ready, o4_valid, o4_last, o4_ovf, busy4, err4;
  logic signed [17:0] o4_data;

  mm_matvec_stream #(.N(3), .NBITS(16), .RESULT_WIDTH(32), .SATURATE(1'b1)) d3 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
    .in_last(in3_last), .out_valid(o3_valid), .out_ready(out_ready), .out_data(o3_data),
    .out_last(o3_last), .out_ovf(o3_ovf), .busy(busy3), .err(err3));

  mm_matvec_stream #(.N(3), .NBITS(16), .RESULT_WIDTH(32), .SATURATE(1'b0)) d3w (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3w_ready), .in_data(in3_data),
    .in_last(in3_last), .out_valid(o3w_valid), .out_ready(out_ready), .out_data(o3w_data),
    .out_last(o3w_last), .out_ovf(o3w_ovf), .busy(busy3w), .err(err3w));

  mm_matvec_stream #(.N(4), .NBITS(8), .RESULT_WIDTH(18), .SATURATE(1'b1)) d4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data),
    .in_last(in4_last), .out_valid(o4_valid), .out_ready(1'b1), .out_data(o4_data),
    .out_last(o4_last), .out_ovf(o4_ovf), .busy(busy4), .err(err4));

  int     n_chk  = 0;
  int     n_fail = 0;
  longint ops [20];
  exp_t   q3[$], q3w[$], q4[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference conversion of a full-precision sum to an rw-bit result.
  function automatic longint conv(input longint v, input int rw, input bit sat, output bit o);
    longint mx, mn, m, w;
    mx = (longint'(1) <<< (rw - 1)) - 1;
    mn = -mx - 1;
    o  = (v > mx) || (v < mn);
    if (!sat) begin
      m = longint'(1) <<< rw;
      w = v & (m - 1);
      if (w > mx) w = w - m;
      return w;
    end
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic push_model(input bit sel);
    int     n;
    longint s;
    bit     o;
    exp_t   e;
    n = sel ? 4 : 3;
    for (int i = 0; i < n; i++) begin
      s = 0;
      for (int k = 0; k < n; k++) s += ops[i*n+k] * ops[n*n+k];
      e.l = (i == n - 1);
      if (sel) begin
        e.d = conv(s, 18, 1'b1, o); e.o = o; q4.push_back(e);
      end else begin
        e.d = conv(s, 32, 1'b1, o); e.o = o; q3.push_back(e);
        e.d = conv(s, 32, 1'b0, o); e.o = o; q3w.push_back(e);
      end
    end
  endtask

  task automatic push3(input longint d, input bit o, input bit l, input longint dw, input bit ow);
    exp_t e;
    e.d = d;  e.o = o;  e.l = l; q3.push_back(e);
    e.d = dw; e.o = ow;          q3w.push_back(e);
  endtask

  task automatic push4(input longint d, input bit o, input bit l);
    exp_t e;
    e.d = d; e.o = o; e.l = l;
    q4.push_back(e);
  endtask

  task automatic fill_rand(input int nops, input bit narrow);
    logic [31:0] x;
    for (int i = 0; i < nops; i++) begin
      x = $urandom;
      ops[i] = narrow ? longint'($signed(x[7:0])) : longint'($signed(x[15:0]));
    end
  endtask

  // Drives ops[0..nops-1]; in_last is raised on beat last_pos.
  task automatic send(input bit sel, input int nops, input bit bub, input int last_pos);
    bit ok;
    int g;
    for (int b = 0; b < nops; b++) begin
      if (bub) begin
        g = $urandom_range(0, 3);
        in3_valid = 1'b0; in4_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      if (sel) begin
        in4_valid = 1'b1; in4_data = 8'(ops[b]); in4_last = (b == last_pos);
      end else begin
        in3_valid = 1'b1; in3_data = 16'(ops[b]); in3_last = (b == last_pos);
      end
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        ok = sel ? in4_ready : in3_ready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        $display("FAIL send_timeout: beat %0d never accepted, expected acceptance", b);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
      end
    end
    in3_valid = 1'b0; in3_last = 1'b0;
    in4_valid = 1'b0; in4_last = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int t;
    t = 0;
    while ((q3.size() > 0 || q3w.size() > 0 || q4.size() > 0) && t < 2000) begin
      if (bp) out_ready = (t < 31) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
      if (bp && q3.size() > 0) check("in_ready_during_output", in3_ready, 0);
    end
    out_ready = 1'b1;
    check("drain_remaining", q3.size() + q3w.size() + q4.size(), 0);
  endtask

  bit     stall3 = 1'b0;
  longint held3  = 0;
  exp_t   e3, e3w, e4;

  always @(negedge clk) begin
    if (rst) begin
      stall3 = 1'b0;
    end else if (o3_valid) begin
      if (stall3) check("c3_hold", o3_data, held3);
      if (out_ready) begin
        stall3 = 1'b0;
        if (q3.size() == 0) check("c3_unexpected", 1, 0);
        else begin
          e3 = q3.pop_front();
          check("c3_data", o3_data, e3.d);
          check("c3_ovf", o3_ovf, e3.o);
          check("c3_last", o3_last, e3.l);
        end
      end else begin
        stall3 = 1'b1;
        held3  = o3_data;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && o3w_valid && out_ready) begin
      if (q3w.size() == 0) check("c3w_unexpected", 1, 0);
      else begin
        e3w = q3w.pop_front();
        check("c3w_data", o3w_data, e3w.d);
        check("c3w_ovf", o3w_ovf, e3w.o);
        check("c3w_last", o3w_last, e3w.l);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && o4_valid) begin
      if (q4.size() == 0) check("c4_unexpected", 1, 0);
      else begin
        e4 = q4.pop_front();
        check("c4_data", o4_data, e4.d);
        check("c4_ovf", o4_ovf, e4.o);
        check("c4_last", o4_last, e4.l);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in3_ready, 1);
    check("rst_out_valid", o3_valid, 0);
    check("rst_out_data", o3_data, 0);
    check("rst_out_last", o3_last, 0);
    check("rst_out_ovf", o3_ovf, 0);
    check("rst_busy", busy3, 0);
    check("rst_err", err3, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic vector with hand-computed results
    ops = '{-12345, 2468, -31000, 15874, -8765, 9999, -32768, 32767, 5432,
            -11111, 22222, -13579, 0, 0, 0, 0, 0, 0, 0, 0};
    push3(612958191, 0, 0, 612958191, 0);
    push3(-506928265, 0, 0, -506928265, 0);
    push3(1018472394, 0, 1, 1018472394, 0);
    send(0, 12, 0, 11);
    k = 0;
    for (int t = 1; t <= 40 && k == 0; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        check("busy_compute", busy3, 1);
        check("in_ready_compute", in3_ready, 0);
      end
      if (o3_valid) k = t;
    end
    check("latency", k, 11);
    drain(0);
    check("err_clean", err3, 0);

    // Saturation / wrap with stalled then random back-pressure
    for (int i = 0; i < 12; i++) ops[i] = -32768;
    for (int i = 0; i < 3; i++) push3(2147483647, 1, i == 2, -1073741824, 1);
    send(0, 12, 0, 11);
    drain(1);

    // Random vectors with input bubbles
    fill_rand(12, 0);
    push_model(0);
    send(0, 12, 1, 11);
    drain(0);
    check("err_bubbles", err3, 0);

    // in_last on beat 5 flags a sticky error; sequencing is unaffected
    fill_rand(12, 0);
    push_model(0);
    send(0, 12, 0, 5);
    drain(0);
    check("err_set", err3, 1);
    fill_rand(12, 0);
    push_model(0);
    send(0, 12, 1, 11);
    drain(0);
    check("err_sticky", err3, 1);

    // Reset during COMPUTE
    fill_rand(12, 0);
    send(0, 12, 0, 11);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check("midrst_busy", busy3, 0);
    check("midrst_in_ready", in3_ready, 1);
    check("midrst_err", err3, 0);
    @(posedge clk); #1; rst = 1'b0;
    fill_rand(12, 0);
    push_model(0);
    send(0, 12, 0, 11);
    drain(0);

    // Reset while a result is stalled on the output
    out_ready = 1'b0;
    fill_rand(12, 0);
    send(0, 12, 0, 11);
    k = 0;
    for (int t = 1; t <= 40 && k == 0; t++) begin
      @(posedge clk); #1;
      if (o3_valid) k = t;
    end
    check("stall_latency", k, 11);
    #1; rst = 1'b1;
    #1;
    check("outrst_valid", o3_valid, 0);
    check("outrst_data", o3_data, 0);
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;

    // N=4, 8-bit operands, 18-bit result
    for (int i = 0; i < 20; i++) ops[i] = 127;
    for (int i = 0; i < 4; i++) push4(64516, 0, i == 3);
    send(1, 20, 0, 19);
    drain(0);
    for (int i = 0; i < 20; i++) ops[i] = -128;
    for (int i = 0; i < 4; i++) push4(65536, 0, i == 3);
    send(1, 20, 0, 19);
    drain(0);
    fill_rand(20, 1);
    push_model(1);
    send(1, 20, 1, 19);
    drain(0);
    check("err4_clean", err4, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
